// File: rtl/rbm_mem_responder_if.sv
// Bus bundle for rbm_mem_responder: read/write request channels plus the word-memory port.
// The slave modport is the responder side; master is the requester/memory side.
interface rbm_mem_responder_if #(
  parameter int MEM_AW = 16
);
  logic              rd_request;
  logic [31:0]       rd_index;
  logic [31:0]       rd_length;
  logic              rd_grant;
  logic              rd_valid;
  logic [31:0]       data_in;
  logic              rd_done;

  logic              wr_request;
  logic [31:0]       wr_index;
  logic [31:0]       wr_length;
  logic              wr_grant;
  logic              wr_valid;
  logic [31:0]       data_out;
  logic              wr_done;

  logic [MEM_AW-1:0] mem_addr;
  logic              mem_rd_en;
  logic [31:0]       mem_rdata;
  logic              mem_wr_en;
  logic [31:0]       mem_wdata;
  logic              err;

  modport slave (
    input  rd_request, rd_index, rd_length, wr_request, wr_index, wr_length,
           wr_valid, data_out, mem_rdata,
    output rd_grant, rd_valid, data_in, rd_done, wr_grant, wr_done,
           mem_addr, mem_rd_en, mem_wr_en, mem_wdata, err
  );

  modport master (
    output rd_request, rd_index, rd_length, wr_request, wr_index, wr_length,
           wr_valid, data_out, mem_rdata,
    input  rd_grant, rd_valid, data_in, rd_done, wr_grant, wr_done,
           mem_addr, mem_rd_en, mem_wr_en, mem_wdata, err
  );
endinterface

// File: rtl/rbm_mem_responder.sv
// Burst read/write responder in front of a 1-cycle-latency word memory.
// Define RBM_RESP_BOUND_CHECK_EN to reject bursts running past the end of memory (err pulse).
module rbm_mem_responder #(
  parameter int MEM_AW = 16
) (
  input logic clk,
  input logic rst,
  rbm_mem_responder_if.slave bus
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] RD_GRANT  = 3'd1;
  localparam logic [2:0] RD_STREAM = 3'd2;
  localparam logic [2:0] RD_DRAIN  = 3'd3;
  localparam logic [2:0] WR_GRANT  = 3'd4;
  localparam logic [2:0] WR_STREAM = 3'd5;
  localparam logic [2:0] DONE      = 3'd6;

  logic [2:0]  state;
  logic [31:0] base;
  logic [31:0] len;
  logic [31:0] beat;
  logic        is_read;
  logic        rd_valid_q;
  logic        bound_err;
  logic [31:0] addr_full;
  logic        rd_issue;
  logic        wr_accept;
  logic        unused_addr_hi;

  assign addr_full      = base + beat;
  assign unused_addr_hi = ^(addr_full >> MEM_AW);

  // Read beats issue from the grant cycle onward so data returns back-to-back after grant.
  assign rd_issue  = !bound_err && (((state == RD_GRANT) && (len != 32'd0)) || (state == RD_STREAM));
  assign wr_accept = (state == WR_STREAM) && bus.wr_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      base       <= '0;
      len        <= '0;
      beat       <= '0;
      is_read    <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_issue;
      case (state)
        IDLE: begin
          if (bus.rd_request) begin
            base    <= bus.rd_index;
            len     <= bus.rd_length;
            beat    <= '0;
            is_read <= 1'b1;
            state   <= RD_GRANT;
          end else if (bus.wr_request) begin
            base    <= bus.wr_index;
            len     <= bus.wr_length;
            beat    <= '0;
            is_read <= 1'b0;
            state   <= WR_GRANT;
          end
        end
        RD_GRANT: begin
          if ((len == 32'd0) || bound_err) begin
            state <= DONE;
          end else begin
            beat  <= 32'd1;
            state <= (len == 32'd1) ? RD_DRAIN : RD_STREAM;
          end
        end
        RD_STREAM: begin
          beat <= beat + 32'd1;
          if (beat == len - 32'd1) state <= RD_DRAIN;
        end
        RD_DRAIN: state <= DONE;
        WR_GRANT: state <= ((len == 32'd0) || bound_err) ? DONE : WR_STREAM;
        WR_STREAM: begin
          if (bus.wr_valid) begin
            beat <= beat + 32'd1;
            if (beat == len - 32'd1) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RBM_RESP_BOUND_CHECK_EN
  logic [32:0] rd_end;
  logic [32:0] wr_end;
  logic [32:0] mem_words;

  assign rd_end    = {1'b0, bus.rd_index} + {1'b0, bus.rd_length};
  assign wr_end    = {1'b0, bus.wr_index} + {1'b0, bus.wr_length};
  assign mem_words = 33'd1 << MEM_AW;

  // Judged once at acceptance, using the same priority as the request arbitration.
  always_ff @(posedge clk) begin
    if (rst) begin
      bound_err <= 1'b0;
    end else if (state == IDLE) begin
      bound_err <= bus.rd_request ? (rd_end > mem_words)
                                  : (bus.wr_request && (wr_end > mem_words));
    end
  end

  assign bus.err = (state == DONE) && bound_err;
`else
  assign bound_err = 1'b0;
  assign bus.err   = 1'b0;
`endif

  assign bus.rd_grant  = (state == RD_GRANT);
  assign bus.wr_grant  = (state == WR_GRANT);
  assign bus.rd_done   = (state == DONE) && is_read;
  assign bus.wr_done   = (state == DONE) && !is_read;
  assign bus.mem_rd_en = rd_issue;
  assign bus.mem_wr_en = wr_accept;
  assign bus.mem_addr  = (rd_issue || wr_accept) ? addr_full[MEM_AW-1:0] : '0;
  assign bus.mem_wdata = wr_accept ? bus.data_out : '0;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.data_in   = rd_valid_q ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_rbm_mem_responder.sv
// Directed, table-driven bench for rbm_mem_responder (16-bit and 4-bit address instances).
// Expectations follow RBM_RESP_BOUND_CHECK_EN when it is defined.
module tb_rbm_mem_responder;

  localparam logic [31:0] MB = 32'hD000_0000;

  typedef struct {
    bit          rst;
    bit          rrq;
    logic [31:0] ridx;
    logic [31:0] rlen;
    bit          wrq;
    logic [31:0] widx;
    logic [31:0] wlen;
    bit          wv;
    logic [31:0] wd;
    bit          e_rg;
    bit          e_rv;
    logic [31:0] e_din;
    bit          e_rdn;
    bit          e_wg;
    bit          e_wdn;
    bit          e_re;
    bit          e_we;
    logic [15:0] e_addr;
    logic [31:0] e_wdata;
    bit          e_err;
  } vec_t;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;
  int   overlap_cnt;

  rbm_mem_responder_if #(.MEM_AW(16)) b16 ();
  rbm_mem_responder_if #(.MEM_AW(4))  b4 ();

  rbm_mem_responder #(.MEM_AW(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));
  rbm_mem_responder #(.MEM_AW(4))  dut4  (.clk(clk), .rst(rst), .bus(b4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: word = MB + address one cycle after a read, junk otherwise.
  always @(posedge clk) begin
    b16.mem_rdata <= b16.mem_rd_en ? (MB + 32'(b16.mem_addr)) : 32'hDEAD_BEEF;
    b4.mem_rdata  <= b4.mem_rd_en  ? (MB + 32'(b4.mem_addr))  : 32'hDEAD_BEEF;
  end

  always @(negedge clk) begin
    if ((b16.mem_rd_en && b16.mem_wr_en) || (b4.mem_rd_en && b4.mem_wr_en)) overlap_cnt++;
  end

  function automatic vec_t row(bit rs, bit rrq, logic [31:0] ridx, logic [31:0] rlen,
                               bit wrq, logic [31:0] widx, logic [31:0] wlen, bit wv, logic [31:0] wd,
                               bit rg, bit rv, logic [31:0] din, bit rdn, bit wg, bit wdn,
                               bit re, bit we, logic [15:0] addr, logic [31:0] wdata, bit er);
    vec_t v;
    v.rst = rs;  v.rrq = rrq; v.ridx = ridx; v.rlen = rlen;
    v.wrq = wrq; v.widx = widx; v.wlen = wlen; v.wv = wv; v.wd = wd;
    v.e_rg = rg; v.e_rv = rv; v.e_din = din; v.e_rdn = rdn; v.e_wg = wg; v.e_wdn = wdn;
    v.e_re = re; v.e_we = we; v.e_addr = addr; v.e_wdata = wdata; v.e_err = er;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input bit sel);
    @(negedge clk);
    rst = v.rst;
    if (sel) begin
      b4.rd_request = v.rrq; b4.rd_index = v.ridx; b4.rd_length = v.rlen;
      b4.wr_request = v.wrq; b4.wr_index = v.widx; b4.wr_length = v.wlen;
      b4.wr_valid   = v.wv;  b4.data_out = v.wd;
    end else begin
      b16.rd_request = v.rrq; b16.rd_index = v.ridx; b16.rd_length = v.rlen;
      b16.wr_request = v.wrq; b16.wr_index = v.widx; b16.wr_length = v.wlen;
      b16.wr_valid   = v.wv;  b16.data_out = v.wd;
    end
    #2;
  endtask

  task automatic checkOutput(input vec_t v, input bit sel, input string tag, input int idx);
    logic rg, rv, rdn, wg, wdn, re, we, er;
    logic [31:0] din, wdat;
    logic [15:0] addr;
    string p;
    if (sel) begin
      rg = b4.rd_grant; rv = b4.rd_valid; din = b4.data_in; rdn = b4.rd_done;
      wg = b4.wr_grant; wdn = b4.wr_done; re = b4.mem_rd_en; we = b4.mem_wr_en;
      addr = {12'd0, b4.mem_addr}; wdat = b4.mem_wdata; er = b4.err;
    end else begin
      rg = b16.rd_grant; rv = b16.rd_valid; din = b16.data_in; rdn = b16.rd_done;
      wg = b16.wr_grant; wdn = b16.wr_done; re = b16.mem_rd_en; we = b16.mem_wr_en;
      addr = b16.mem_addr; wdat = b16.mem_wdata; er = b16.err;
    end
    p = $sformatf("%s[%0d]", tag, idx);
    cmp({p, ".rd_grant"},  32'(rg),  32'(v.e_rg));
    cmp({p, ".rd_valid"},  32'(rv),  32'(v.e_rv));
    cmp({p, ".rd_done"},   32'(rdn), 32'(v.e_rdn));
    cmp({p, ".wr_grant"},  32'(wg),  32'(v.e_wg));
    cmp({p, ".wr_done"},   32'(wdn), 32'(v.e_wdn));
    cmp({p, ".mem_rd_en"}, 32'(re),  32'(v.e_re));
    cmp({p, ".mem_wr_en"}, 32'(we),  32'(v.e_we));
    cmp({p, ".err"},       32'(er),  32'(v.e_err));
    if (v.e_rv) cmp({p, ".data_in"}, din, v.e_din);
    if (v.e_re || v.e_we) cmp({p, ".mem_addr"}, 32'(addr), 32'(v.e_addr));
    if (v.e_we) cmp({p, ".mem_wdata"}, wdat, v.e_wdata);
  endtask

  vec_t tbl[$];
  vec_t rst_seq[$];
  vec_t wrap_seq[$];

  initial begin
    tests_run = 0; tests_failed = 0; overlap_cnt = 0;
    rst = 1'b1;
    b16.rd_request = 0; b16.rd_index = 0; b16.rd_length = 0; b16.wr_request = 0;
    b16.wr_index = 0; b16.wr_length = 0; b16.wr_valid = 0; b16.data_out = 0;
    b4.rd_request = 0; b4.rd_index = 0; b4.rd_length = 0; b4.wr_request = 0;
    b4.wr_index = 0; b4.wr_length = 0; b4.wr_valid = 0; b4.data_out = 0;

    // 5-beat read at 0x10
    tbl.push_back(row(1, 0,0,0, 0,0,0, 0,0,           0,0,0,0, 0,0, 0,0,0,0, 0));
    tbl.push_back(row(0, 1,'h10,5, 0,0,0, 0,0,        0,0,0,0, 0,0, 0,0,0,0, 0));
    tbl.push_back(row(0, 0,0,0, 0,0,0, 0,0,           1,0,0,0, 0,0, 1,0,'h10,0, 0));
    tbl.push_back(row(0, 0,0,0, 0,0,0, 0,0,           0,1,MB+'h10,0, 0,0, 1,0,'h11,0, 0));
    tbl.push_back(row(0, 0,0,0, 0,0,0, 0,0,           0,1,MB+'h11,0, 0,0, 1,0,'h12,0, 0));
    tbl.push_back(row(0, 0,0,0, 0,0,0, 0,0,           0,1,MB+'h12,0, 0,0, 1,0,'h13,0, 0));
    tbl.push_back(row(0, 0,0,0, 0,0,0, 0,0,           0,1,MB+'h13,0, 0,0, 1,0,'h14,0, 0));
    tbl.push_back(row(0, 0,0,0, 0,0,0, 0,0,           0,1,MB+'h14,0, 0,0, 0,0,0,0, 0));
    tbl.push_back(row(0, 0,0,0, 0,0,0, 0,0,           0,0,0,1, 0,0, 0,0,0,0, 0));
    tbl.push_back(row(0, 0,0,0, 0,0,0, 0,0,           0,0,0,0, 0,0, 0,0,0,0, 0));
    // simultaneous requests: read first, held write afterwards with gaps
    tbl.push_back(row(0, 1,'h40,2, 1,'h20,3, 0,0,     0,0,0,0, 0,0, 0,0,0,0, 0));
    tbl.push_back(row(0, 0,0,0, 1,'h20,3, 0,0,        1,0,0,0, 0,0, 1,0,'h40,0, 0));
    tbl.push_back(row(0, 0,0,0, 1,'h20,3, 0,0,        0,1,MB+'h40,0, 0,0, 1,0,'h41,0, 0));
    tbl.push_back(row(0, 0,0,0, 1,'h20,3, 0,0,        0,1,MB+'h41,0, 0,0, 0,0,0,0, 0));
    tbl.push_back(row(0, 0,0,0, 1,'h20,3, 0,0,        0,0,0,1, 0,0, 0,0,0,0, 0));
    tbl.push_back(row(0, 0,0,0, 1,'h20,3, 0,0,        0,0,0,0, 0,0, 0,0,0,0, 0));
    tbl.push_back(row(0, 0,0,0, 0,0,0, 1,'hBAD0BAD0,  0,0,0,0, 1,0, 0,0,0,0, 0));
    tbl.push_back(row(0, 0,0,0, 0,0,0, 1,'h11111111,  0,0,0,0, 0,0, 0,1,'h20,'h11111111, 0));
    tbl.push_back(row(0, 0,0,0, 0,0,0, 0,'h99999999,  0,0,0,0, 0,0, 0,0,0,0, 0));
    tbl.push_back(row(0, 0,0,0, 0,0,0, 1,'h22222222,  0,0,0,0, 0,0, 0,1,'h21,'h22222222, 0));
    tbl.push_back(row(0, 0,0,0, 0,0,0, 1,'h33333333,  0,0,0,0, 0,0, 0,1,'h22,'h33333333, 0));
    tbl.push_back(row(0, 0,0,0, 0,0,0, 1,'h44444444,  0,0,0,0, 0,1, 0,0,0,0, 0));
    tbl.push_back(row(0, 0,0,0, 0,0,0, 0,0,           0,0,0,0, 0,0, 0,0,0,0, 0));
    // zero-length read and write
    tbl.push_back(row(0, 1,'h50,0, 0,0,0, 0,0,        0,0,0,0, 0,0, 0,0,0,0, 0));
    tbl.push_back(row(0, 0,0,0, 0,0,0, 0,0,           1,0,0,0, 0,0, 0,0,0,0, 0));
    tbl.push_back(row(0, 0,0,0, 0,0,0, 0,0,           0,0,0,1, 0,0, 0,0,0,0, 0));
    tbl.push_back(row(0, 0,0,0, 0,0,0, 0,0,           0,0,0,0, 0,0, 0,0,0,0, 0));
    tbl.push_back(row(0, 0,0,0, 1,'h60,0, 0,0,        0,0,0,0, 0,0, 0,0,0,0, 0));
    tbl.push_back(row(0, 0,0,0, 0,0,0, 0,0,           0,0,0,0, 1,0, 0,0,0,0, 0));
    tbl.push_back(row(0, 0,0,0, 0,0,0, 0,0,           0,0,0,0, 0,1, 0,0,0,0, 0));
    tbl.push_back(row(0, 0,0,0, 0,0,0, 0,0,           0,0,0,0, 0,0, 0,0,0,0, 0));

    // reset while beat 2 of an 8-beat read is issued, then a fresh 1-beat read
    rst_seq.push_back(row(0, 1,'h100,8, 0,0,0, 0,0,   0,0,0,0, 0,0, 0,0,0,0, 0));
    rst_seq.push_back(row(0, 0,0,0, 0,0,0, 0,0,       1,0,0,0, 0,0, 1,0,'h100,0, 0));
    rst_seq.push_back(row(0, 0,0,0, 0,0,0, 0,0,       0,1,MB+'h100,0, 0,0, 1,0,'h101,0, 0));
    rst_seq.push_back(row(1, 0,0,0, 0,0,0, 0,0,       0,1,MB+'h101,0, 0,0, 1,0,'h102,0, 0));
    rst_seq.push_back(row(0, 0,0,0, 0,0,0, 0,0,       0,0,0,0, 0,0, 0,0,0,0, 0));
    rst_seq.push_back(row(0, 0,0,0, 0,0,0, 0,0,       0,0,0,0, 0,0, 0,0,0,0, 0));
    rst_seq.push_back(row(0, 0,0,0, 0,0,0, 0,0,       0,0,0,0, 0,0, 0,0,0,0, 0));
    rst_seq.push_back(row(0, 1,'h200,1, 0,0,0, 0,0,   0,0,0,0, 0,0, 0,0,0,0, 0));
    rst_seq.push_back(row(0, 0,0,0, 0,0,0, 0,0,       1,0,0,0, 0,0, 1,0,'h200,0, 0));
    rst_seq.push_back(row(0, 0,0,0, 0,0,0, 0,0,       0,1,MB+'h200,0, 0,0, 0,0,0,0, 0));
    rst_seq.push_back(row(0, 0,0,0, 0,0,0, 0,0,       0,0,0,1, 0,0, 0,0,0,0, 0));
    rst_seq.push_back(row(0, 0,0,0, 0,0,0, 0,0,       0,0,0,0, 0,0, 0,0,0,0, 0));

    // 4-bit memory: read of 4 words from index 14 crosses the top of memory
    wrap_seq.push_back(row(0, 1,14,4, 0,0,0, 0,0,     0,0,0,0, 0,0, 0,0,0,0, 0));
`ifdef RBM_RESP_BOUND_CHECK_EN
    wrap_seq.push_back(row(0, 0,0,0, 0,0,0, 0,0,      1,0,0,0, 0,0, 0,0,0,0, 0));
    wrap_seq.push_back(row(0, 0,0,0, 0,0,0, 0,0,      0,0,0,1, 0,0, 0,0,0,0, 1));
    wrap_seq.push_back(row(0, 0,0,0, 0,0,0, 0,0,      0,0,0,0, 0,0, 0,0,0,0, 0));
`else
    wrap_seq.push_back(row(0, 0,0,0, 0,0,0, 0,0,      1,0,0,0, 0,0, 1,0,14,0, 0));
    wrap_seq.push_back(row(0, 0,0,0, 0,0,0, 0,0,      0,1,MB+14,0, 0,0, 1,0,15,0, 0));
    wrap_seq.push_back(row(0, 0,0,0, 0,0,0, 0,0,      0,1,MB+15,0, 0,0, 1,0,0,0, 0));
    wrap_seq.push_back(row(0, 0,0,0, 0,0,0, 0,0,      0,1,MB+0,0, 0,0, 1,0,1,0, 0));
    wrap_seq.push_back(row(0, 0,0,0, 0,0,0, 0,0,      0,1,MB+1,0, 0,0, 0,0,0,0, 0));
    wrap_seq.push_back(row(0, 0,0,0, 0,0,0, 0,0,      0,0,0,1, 0,0, 0,0,0,0, 0));
    wrap_seq.push_back(row(0, 0,0,0, 0,0,0, 0,0,      0,0,0,0, 0,0, 0,0,0,0, 0));
`endif

    repeat (2) @(posedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i], 1'b0);
      checkOutput(tbl[i], 1'b0, "main", i);
    end
    for (int i = 0; i < rst_seq.size(); i++) begin
      applyStimulus(rst_seq[i], 1'b0);
      checkOutput(rst_seq[i], 1'b0, "reset", i);
    end
    for (int i = 0; i < wrap_seq.size(); i++) begin
      applyStimulus(wrap_seq[i], 1'b1);
      checkOutput(wrap_seq[i], 1'b1, "wrap", i);
    end

    cmp("rd_wr_overlap", 32'(overlap_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
